mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Multi-cycle control sequencer for the MIPS-subset core. It is driven by the opcode/funct fields that the instruction decoder extracts from the latched instruction register. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and emits every datapath strobe. It also handshakes with instruction and data memories that may stall.

Parameters:
RESET_STATE, 3'd0, state entered on reset (FETCH); not intended to be overridden
ALU_OP_W, 4, width of alu_op output

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode_instr  in  6  instr[31:26] from decoder (sampled in DECODE)
funct_instr  in  6  instr[5:0] from decoder
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
alu_zero  in  1  ALU zero flag (valid in EXEC)
imem_req  out  1  fetch request
ir_load  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  2  0=PC+4, 1=branch target, 2=jump target {PC[31:28],addr,2'b00}, 3=rs (jr)
alu_op  out  ALU_OP_W  0=add 1=sub 2=and 3=or 4=slt 5=sll
alu_src_b  out  1  0=rt, 1=sign-extended imm
reg_dst  out  1  0=rt, 1=rd
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback source 0=ALU, 1=memory
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (valid with dmem_req)
illegal  out  1  sticky unsupported-instruction flag
retire  out  1  one-cycle pulse on instruction completion
state  out  3  current state, for debug

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH. All outputs=0, including imem_req, illegal and retire. After release, FETCH drives imem_req=1 from the first clock edge onward.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. All outputs are decoded from state plus the opcode/funct registered in DECODE. The only inputs used combinationally are imem_ready, dmem_ready and alu_zero.
- FETCH:
  - imem_req=1.
  - If imem_ready=0: stay in FETCH.
  - If imem_ready=1: ir_load=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: register opcode/funct internally. Transitions:
  - Supported opcode: EXEC.
  - Unsupported opcode, or unsupported funct with opcode 000000: set illegal=1 and go to HALT.
- Supported set:
  - R-type (op 000000): funct add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, jr 001000.
  - I/J-type: lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- EXEC, by instruction:
  - R-type ALU ops: alu_src_b=0, alu_op from funct, then WB.
  - addi, lw, sw: alu_op=add, alu_src_b=1.
    - addi goes to WB.
    - lw and sw go to MEM.
  - beq:
    - alu_op=sub, alu_src_b=0.
    - pc_write=alu_zero, pc_src=1.
    - retire=1, then FETCH.
  - j: pc_write=1, pc_src=2, retire=1, then FETCH.
  - jr: pc_write=1, pc_src=3, retire=1, then FETCH.
- MEM: dmem_req=1, with dmem_we=1 for sw and 0 for lw.
  - If dmem_ready=0: stay in MEM; outputs held.
  - If dmem_ready=1:
    - lw goes to WB.
    - sw asserts retire=1 and goes to FETCH.
- WB:
  - reg_write=1 for exactly one cycle.
  - reg_dst=1 for R-type, 0 for addi/lw.
  - mem_to_reg=1 only for lw.
  - retire=1, then FETCH.
- HALT: all strobes 0 and illegal held at 1. Only rst_n exits HALT.
- Latencies with zero-wait memories, from FETCH entry to retire cycle inclusive:
  - beq, j, jr: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle on a ready signal adds one cycle.
- Strobe counts per instruction: pc_write, reg_write and ir_load are asserted at most once each, except that beq/j/jr add a second pc_write in EXEC.
- Stability: outputs do not glitch on decoder inputs outside DECODE, because the registered opcode/funct are used.
- Reset mid-operation: an asserted rst_n aborts any state immediately and clears all outputs. A pending memory handshake is dropped.

Test Plan:
- add (op 000000, funct 100000), imem_ready=dmem_ready=1 -> states 0,1,2,4; alu_op=0 in EXEC; reg_write=1, reg_dst=1 in WB; retire pulse in cycle 4.
- lw (op 100011) with dmem_ready low for 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0; then WB with mem_to_reg=1; retire in cycle 8.
- beq (op 000100): alu_zero=1 -> pc_write=1, pc_src=1 in EXEC. alu_zero=0 -> pc_write=0 in EXEC. Both cases retire in cycle 3.
- j (op 000010) then jr (funct 001000) -> pc_src=2 then 3 in the respective EXEC cycles; no reg_write or dmem_req at any point.
- Illegal opcode 111111 -> illegal=1 after DECODE; state=7 for 20 further cycles with imem_req=0; only rst_n clears it.
- rst_n asserted asynchronously mid-MEM of sw -> dmem_req drops without waiting for a clock; after release, state=0 and imem_req=1; no retire was emitted for the aborted sw.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle control sequencer for the MIPS-subset core: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB and drives every datapath strobe from state.
module mc_control_fsm #(
  parameter logic [2:0] RESET_STATE = 3'd0,
  parameter int         ALU_OP_W    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode_instr,
  input  logic [5:0]          funct_instr,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                alu_zero,
  output logic                imem_req,
  output logic                ir_load,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_b,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                illegal,
  output logic                retire,
  output logic [2:0]          state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd7;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;

  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_JR: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [2:0] state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] fn_q, fn_d;
  logic       illegal_q, illegal_d;
  // Holds every strobe low until the first clock edge after reset release.
  logic       run_q;

  logic is_r, is_jr, is_lw, is_sw, is_beq, is_j;
  logic [ALU_OP_W-1:0] r_alu_op;

  assign is_r   = (op_q == OP_RTYPE);
  assign is_jr  = is_r && (fn_q == FN_JR);
  assign is_lw  = (op_q == OP_LW);
  assign is_sw  = (op_q == OP_SW);
  assign is_beq = (op_q == OP_BEQ);
  assign is_j   = (op_q == OP_J);

  always_comb begin
    case (fn_q)
      FN_SUB:  r_alu_op = ALU_OP_W'(1);
      FN_AND:  r_alu_op = ALU_OP_W'(2);
      FN_OR:   r_alu_op = ALU_OP_W'(3);
      FN_SLT:  r_alu_op = ALU_OP_W'(4);
      FN_SLL:  r_alu_op = ALU_OP_W'(5);
      default: r_alu_op = ALU_OP_W'(0);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    fn_d       = fn_q;
    illegal_d  = illegal_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    alu_op     = ALU_OP_W'(0);
    alu_src_b  = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    retire     = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load  = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          op_d = opcode_instr;
          fn_d = funct_instr;
          if (is_legal(opcode_instr, funct_instr)) begin
            state_d = S_EXEC;
          end else begin
            illegal_d = 1'b1;
            state_d   = S_HALT;
          end
        end
        S_EXEC: begin
          if (is_beq) begin
            alu_op   = ALU_OP_W'(1);
            pc_write = alu_zero;
            pc_src   = 2'd1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else if (is_j || is_jr) begin
            pc_write = 1'b1;
            pc_src   = is_j ? 2'd2 : 2'd3;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else if (is_r) begin
            alu_op  = r_alu_op;
            state_d = S_WB;
          end else begin
            // addi, lw and sw all compute rs + sign-extended immediate.
            alu_src_b = 1'b1;
            state_d   = (is_lw || is_sw) ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = is_sw;
          if (dmem_ready) begin
            if (is_sw) begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = is_r;
          mem_to_reg = is_lw;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      op_q      <= 6'd0;
      fn_q      <= 6'd0;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      fn_q      <= fn_d;
      illegal_q <= illegal_d;
      run_q     <= 1'b1;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: drivers push an expected retire snapshot
// (latency + strobes) into a queue that a negedge monitor pops on each retire.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       imem_ready, dmem_ready, alu_zero;
  logic       imem_req, ir_load, pc_write, alu_src_b, reg_dst, reg_write;
  logic       mem_to_reg, dmem_req, dmem_we, illegal, retire;
  logic [1:0] pc_src;
  logic [3:0] alu_op;
  logic [2:0] state;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode_instr(opcode), .funct_instr(funct),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_zero(alu_zero),
    .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .illegal(illegal), .retire(retire), .state(state)
  );

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  // Per-cycle log of the most recent instruction, indexed from its FETCH entry.
  logic [2:0] st_l[64];
  logic [1:0] src_l[64];
  logic [3:0] alu_l[64];
  logic       ir_l[64], pcw_l[64], srcb_l[64], rw_l[64], rd_l[64];
  logic       m2r_l[64], dreq_l[64], dwe_l[64];
  int         ncyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int lat, input logic pw, input logic [1:0] src,
                                     input logic rw, input logic rd, input logic m2r,
                                     input logic dq, input logic dw);
    return {8'(lat), pw, src, rw, rd, m2r, dq, dw};
  endfunction

  function automatic int cnt_rw_dreq();
    int n;
    n = 0;
    for (int i = 0; i < ncyc; i++) n += int'(rw_l[i]) + int'(dreq_l[i]);
    return n;
  endfunction

  function automatic int cnt_pcw();
    int n;
    n = 0;
    for (int i = 0; i < ncyc; i++) n += int'(pcw_l[i]);
    return n;
  endfunction

  function automatic int cnt_ir();
    int n;
    n = 0;
    for (int i = 0; i < ncyc; i++) n += int'(ir_l[i]);
    return n;
  endfunction

  // Monitor: latency counted from FETCH entry; compared on every retire pulse.
  int          mcnt = 0;
  logic [15:0] mon_e, mon_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      mcnt = 0;
    end else if (state != 3'd0 || imem_req) begin
      mcnt++;
      if (retire) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_retire: actual=retire at state %0d required=no retire", state);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = mk(mcnt, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, dmem_req, dmem_we);
          if (mon_a !== mon_e) begin
            failures++;
            $display("FAIL retire_snapshot: actual=%h required=%h", mon_a, mon_e);
          end
        end
        mcnt = 0;
      end
    end
  end

  // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int iw,
                           input int dw, input logic z, input logic [15:0] exp);
    int   i_w, d_w;
    logic done;
    i_w = iw; d_w = dw; done = 1'b0; ncyc = 0;
    exp_q.push_back(exp);
    opcode = op; funct = fn; alu_zero = z;
    for (int c = 0; c < 60 && !done; c++) begin
      if (state == 3'd0) begin imem_ready = (i_w == 0); if (i_w > 0) i_w--; end
      if (state == 3'd3) begin dmem_ready = (d_w == 0); if (d_w > 0) d_w--; end
      @(negedge clk);
      st_l[c] = state; ir_l[c] = ir_load; pcw_l[c] = pc_write; src_l[c] = pc_src;
      alu_l[c] = alu_op; srcb_l[c] = alu_src_b; rw_l[c] = reg_write; rd_l[c] = reg_dst;
      m2r_l[c] = mem_to_reg; dreq_l[c] = dmem_req; dwe_l[c] = dmem_we;
      ncyc = c + 1;
      if (retire) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL retire_timeout: actual=no retire in %0d cycles required=retire", ncyc);
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0; opcode = 6'd0; funct = 6'd0;
    imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("reset_state", 32'(state), 0);
    check("reset_outputs", 32'({imem_req, ir_load, pc_write, pc_src, alu_op, alu_src_b, reg_dst,
                                reg_write, mem_to_reg, dmem_req, dmem_we, illegal, retire}), 0);
    rst_n = 1'b1; #1;
    check("imem_req_before_first_edge", 32'(imem_req), 0);
    @(posedge clk); #1;
    check("imem_req_after_first_edge", 32'(imem_req), 1);

    // add: F D E W, retire in cycle 4
    run_instr(6'b000000, 6'b100000, 0, 0, 1'b0, mk(4, 0, 2'd0, 1, 1, 0, 0, 0));
    check("add_states", 32'({st_l[0], st_l[1], st_l[2], st_l[3]}), 32'({3'd0, 3'd1, 3'd2, 3'd4}));
    check("add_exec_alu_op", 32'(alu_l[2]), 0);
    check("add_wb_reg_dst", 32'({rw_l[3], rd_l[3]}), 32'(2'b11));
    check("add_ir_load_count", 32'(cnt_ir()), 1);

    // sub with two imem wait cycles: latency 6, EXEC at index 4
    run_instr(6'b000000, 6'b100010, 2, 0, 1'b0, mk(6, 0, 2'd0, 1, 1, 0, 0, 0));
    check("sub_exec_alu_op", 32'(alu_l[4]), 1);
    check("sub_exec_state", 32'(st_l[4]), 2);

    // lw with dmem_ready low for 3 cycles: MEM held 4 cycles, retire cycle 8
    run_instr(6'b100011, 6'b000000, 0, 3, 1'b0, mk(8, 0, 2'd0, 1, 0, 1, 0, 0));
    n = 0;
    for (int i = 3; i < 7; i++) if (st_l[i] == 3'd3 && dreq_l[i] && !dwe_l[i]) n++;
    check("lw_mem_hold_cycles", 32'(n), 4);
    check("lw_exec_alu_src_b", 32'(srcb_l[2]), 1);
    check("lw_wb_mem_to_reg", 32'({st_l[7], m2r_l[7], rd_l[7]}), 32'({3'd4, 1'b1, 1'b0}));

    // addi, sw (retires from MEM), slt
    run_instr(6'b001000, 6'b000000, 0, 0, 1'b0, mk(4, 0, 2'd0, 1, 0, 0, 0, 0));
    check("addi_exec_alu_src_b", 32'(srcb_l[2]), 1);
    run_instr(6'b101011, 6'b000000, 0, 0, 1'b0, mk(4, 0, 2'd0, 0, 0, 0, 1, 1));
    run_instr(6'b000000, 6'b101010, 0, 0, 1'b0, mk(4, 0, 2'd0, 1, 1, 0, 0, 0));
    check("slt_exec_alu_op", 32'(alu_l[2]), 4);

    // beq taken / not taken
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b1, mk(3, 1, 2'd1, 0, 0, 0, 0, 0));
    check("beq_taken_exec", 32'({pcw_l[2], src_l[2], alu_l[2]}), 32'({1'b1, 2'd1, 4'd1}));
    check("beq_taken_latency", 32'(ncyc), 3);
    run_instr(6'b000100, 6'b000000, 0, 0, 1'b0, mk(3, 0, 2'd1, 0, 0, 0, 0, 0));
    check("beq_not_taken_pc_write", 32'(pcw_l[2]), 0);

    // j then jr
    run_instr(6'b000010, 6'b000000, 0, 0, 1'b0, mk(3, 1, 2'd2, 0, 0, 0, 0, 0));
    check("j_pc_src", 32'(src_l[2]), 2);
    check("j_no_rw_dreq", 32'(cnt_rw_dreq()), 0);
    run_instr(6'b000000, 6'b001000, 0, 0, 1'b0, mk(3, 1, 2'd3, 0, 0, 0, 0, 0));
    check("jr_pc_src", 32'(src_l[2]), 3);
    check("jr_no_rw_dreq", 32'(cnt_rw_dreq()), 0);
    check("jr_pc_write_count", 32'(cnt_pcw()), 2);

    // sw aborted by asynchronous reset while stalled in MEM
    opcode = 6'b101011; funct = 6'd0; imem_ready = 1'b1; dmem_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("sw_abort_in_mem", 32'({state, dmem_req, dmem_we}), 32'({3'd3, 1'b1, 1'b1}));
    #2 rst_n = 1'b0;
    #1;
    check("sw_abort_async_drop", 32'({state, dmem_req, imem_req}), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("sw_abort_restart", 32'({state, imem_req}), 32'({3'd0, 1'b1}));
    check("sw_abort_no_pending", 32'(exp_q.size()), 0);
    run_instr(6'b000000, 6'b100101, 0, 0, 1'b0, mk(4, 0, 2'd0, 1, 1, 0, 0, 0));
    check("or_exec_alu_op", 32'(alu_l[2]), 3);

    // illegal opcode parks in HALT until reset
    opcode = 6'b111111; imem_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    check("illegal_enter_halt", 32'({state, illegal}), 32'({3'd7, 1'b1}));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (state == 3'd7 && !imem_req && illegal && !retire && !pc_write && !ir_load) n++;
    end
    check("halt_held_20_cycles", 32'(n), 20);
    rst_n = 1'b0; #1;
    check("illegal_cleared_by_reset", 32'({state, illegal}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(6'b001000, 6'b000000, 0, 0, 1'b0, mk(4, 0, 2'd0, 1, 0, 0, 0, 0));
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
